// File: rtl/elevator_call_scheduler_pkg.sv
// Shared definitions for the elevator scheduler, controller and segment decoder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package elevator_call_scheduler_pkg;

    // Default building geometry; the 7-segment display limits this to floors 0-9.
    localparam int NUM_FLOORS_DEF  = 10;
    localparam int FLOOR_W_DEF     = 4;
    localparam int DOOR_CYCLES_DEF = 16;

    // Scheduler FSM encoding; the controller decodes these for its status display.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SELECT      = 2'd1,
        WAIT_ARRIVE = 2'd2,
        DOOR        = 2'd3
    } sched_state_t;

endpackage

// File: rtl/elevator_call_scheduler_call_button_sync.sv
// Call-button front end: per-bit two-flop synchronizer followed by a rising-edge pulse.
// Latency: press sampled at edge k gives a one-cycle pulse after edge k+1.
// Backpressure: none; a held button yields exactly one pulse.
module call_button_sync
    import elevator_call_scheduler_pkg::*;
#(
    parameter int WIDTH = NUM_FLOORS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_rise
);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_stable;
    logic [WIDTH-1:0] sync_prev;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta   <= '0;
            sync_stable <= '0;
            sync_prev   <= '0;
        end else begin
            sync_meta   <= btn_raw;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
        end
    end

    // Pulse only on the 0->1 transition of the synchronized button.
    assign btn_rise = sync_stable & ~sync_prev;

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches call buttons, picks the next target floor, holds it until arrival, runs door dwell.
// Latency: press to pending lamp 3 cycles; pending to req_valid 2 cycles from IDLE.
// Backpressure: req_floor held stable with req_valid until the controller reports arrival at that floor.
module elevator_call_scheduler
    import elevator_call_scheduler_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  arrived,
    output logic                  req_valid,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  floor_err
);

    localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

    sched_state_t          state;
    logic [CNT_W-1:0]      dwell_cnt;
    logic [NUM_FLOORS-1:0] call_rise;
    logic [NUM_FLOORS-1:0] served_mask;
    logic                  floor_bad;
    logic                  arrive_match;
    logic                  up_found;
    logic                  dn_found;
    logic [FLOOR_W-1:0]    up_idx;
    logic [FLOOR_W-1:0]    dn_idx;
    logic                  pick_valid;
    logic [FLOOR_W-1:0]    pick_floor;
    logic                  pick_up;

    call_button_sync #(
        .WIDTH (NUM_FLOORS)
    ) u_call_button_sync (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (call_btn),
        .btn_rise (call_rise)
    );

    // A reported floor outside the building is a controller fault; never dispatch from it.
    assign floor_bad    = int'(current_floor) >= NUM_FLOORS;
    // req_floor is always a legal floor, so an out-of-range current_floor can never match.
    assign arrive_match = arrived && (current_floor == req_floor);
    assign served_mask  = NUM_FLOORS'(1) << req_floor;

    // Priority scan: lowest pending floor at/above the car and highest at/below it.
    always_comb begin
        up_found = 1'b0;
        up_idx   = '0;
        dn_found = 1'b0;
        dn_idx   = '0;
        // Descending walk so the last hit is the lowest floor at/above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= current_floor)) begin
                up_found = 1'b1;
                up_idx   = FLOOR_W'(i);
            end
        end
        // Ascending walk so the last hit is the highest floor at/below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) <= current_floor)) begin
                dn_found = 1'b1;
                dn_idx   = FLOOR_W'(i);
            end
        end
    end

    // SCAN choice: keep direction if anything lies ahead, otherwise reverse to the nearest call behind.
    always_comb begin
        pick_valid = 1'b0;
        pick_floor = '0;
        pick_up    = dir_up;
        if (!floor_bad) begin
            if (dir_up) begin
                if (up_found) begin
                    pick_valid = 1'b1;
                    pick_floor = up_idx;
                end else if (dn_found) begin
                    pick_valid = 1'b1;
                    pick_floor = dn_idx;
                    pick_up    = 1'b0;
                end
            end else begin
                if (dn_found) begin
                    pick_valid = 1'b1;
                    pick_floor = dn_idx;
                end else if (up_found) begin
                    pick_valid = 1'b1;
                    pick_floor = up_idx;
                    pick_up    = 1'b1;
                end
            end
        end
    end

    // Scheduler FSM with registered outputs, pending-call latch and sticky floor fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            req_floor <= '0;
            pending   <= '0;
            dir_up    <= 1'b1;
            door_open <= 1'b0;
            floor_err <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            // New calls always latch; a clear below re-applies call_rise so a same-cycle press wins.
            pending <= pending | call_rise;
            if (floor_bad) begin
                floor_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_valid) begin
                        req_floor <= pick_floor;
                        req_valid <= 1'b1;
                        dir_up    <= pick_up;
                        state     <= WAIT_ARRIVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_ARRIVE: begin
                    // Target is frozen here; calls arriving meanwhile wait for the next SELECT.
                    if (arrive_match) begin
                        pending   <= (pending & ~served_mask) | call_rise;
                        req_valid <= 1'b0;
                        door_open <= 1'b1;
                        dwell_cnt <= '0;
                        state     <= DOOR;
                    end
                end
                DOOR: begin
                    if (dwell_cnt == CNT_W'(DOOR_CYCLES - 1)) begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios then randomized traffic.
// Latency: n/a.
// Backpressure: the bench plays the elevator controller, answering req_floor with travel and arrival.
module tb_elevator_call_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;
    localparam int DC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_btn;
    logic [FW-1:0] current_floor;
    logic          arrived;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          door_open;
    logic          floor_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: call set, synchronizer history, SCAN direction, outstanding target, door timer.
    logic [NF-1:0] m_pend, m_s1, m_s2, m_pv;
    bit            m_dir, m_rv, m_sel, m_err;
    int            m_rf, m_door;

    // Bench-side elevator controller state for the random phase.
    int            travel;
    int            tgt;
    int            hold [NF];

    always #5 clk = ~clk;

    elevator_call_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .arrived       (arrived),
        .req_valid     (req_valid),
        .req_floor     (req_floor),
        .pending       (pending),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .floor_err     (floor_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pend = '0; m_s1 = '0; m_s2 = '0; m_pv = '0;
        m_dir = 1'b1; m_rv = 1'b0; m_sel = 1'b0; m_err = 1'b0;
        m_rf = 0; m_door = 0;
    endtask

    // Predict the effect of the coming clock edge from the inputs now being driven.
    task automatic model_step();
        logic [NF-1:0] sets, clr;
        int cur, up_hit, dn_hit;
        if (reset) begin
            model_clear();
            return;
        end
        cur  = int'(current_floor);
        sets = m_s2 & ~m_pv;
        m_pv = m_s2; m_s2 = m_s1; m_s1 = call_btn;
        clr  = '0;
        if (cur >= NF) m_err = 1'b1;
        if (m_rv) begin
            if (arrived && cur == m_rf) begin
                clr[m_rf] = 1'b1;
                m_rv      = 1'b0;
                m_door    = DC;
            end
        end else if (m_door > 0) begin
            m_door--;
        end else if (m_sel) begin
            m_sel = 1'b0;
            if (m_pend != '0 && cur < NF) begin
                up_hit = -1; dn_hit = -1;
                // Nearest call by distance on each side of the car (distance 0 counts for both).
                for (int d = NF - 1; d >= 0; d--) begin
                    if (cur + d < NF && m_pend[cur + d]) up_hit = cur + d;
                    if (cur - d >= 0 && m_pend[cur - d]) dn_hit = cur - d;
                end
                if (m_dir) begin
                    if (up_hit >= 0) m_rf = up_hit;
                    else begin m_rf = dn_hit; m_dir = 1'b0; end
                end else begin
                    if (dn_hit >= 0) m_rf = dn_hit;
                    else begin m_rf = up_hit; m_dir = 1'b1; end
                end
                m_rv = 1'b1;
            end
        end else if (m_pend != '0) begin
            m_sel = 1'b1;
        end
        m_pend = (m_pend & ~clr) | sets;
    endtask

    task automatic check_all();
        chk("pending",   32'(pending),   32'(m_pend));
        chk("req_valid", 32'(req_valid), 32'(m_rv));
        chk("req_floor", 32'(req_floor), 32'(m_rf));
        chk("dir_up",    32'(dir_up),    32'(m_dir));
        chk("door_open", 32'(door_open), 32'(m_door > 0));
        chk("floor_err", 32'(floor_err), 32'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rv"},   32'(req_valid), 32'd0);
        chk({tag, "_rf"},   32'(req_floor), 32'd0);
        chk({tag, "_pend"}, 32'(pending),   32'd0);
        chk({tag, "_dir"},  32'(dir_up),    32'd1);
        chk({tag, "_door"}, 32'(door_open), 32'd0);
        chk({tag, "_err"},  32'(floor_err), 32'd0);
    endtask

    task automatic wait_rv(input string tag);
        int k;
        k = 0;
        while (!req_valid && k < 60) begin tick(); k++; end
        chk(tag, 32'(req_valid), 32'd1);
    endtask

    task automatic wait_door_done(input string tag);
        int k;
        k = 0;
        while (door_open && k < 60) begin tick(); k++; end
        chk(tag, 32'(door_open), 32'd0);
    endtask

    task automatic press(input int a, input int b);
        call_btn    = '0;
        call_btn[a] = 1'b1;
        call_btn[b] = 1'b1;
        tick();
        call_btn    = '0;
    endtask

    task automatic travel_to(input int f, input string tag);
        arrived = 1'b0;
        repeat (3) tick();
        current_floor = FW'(f);
        arrived       = 1'b1;
        tick();
        chk(tag, 32'(door_open), 32'd1);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; call_btn = '0; current_floor = '0; arrived = 1'b1;
        travel = 0; tgt = 0;
        for (int i = 0; i < NF; i++) hold[i] = 0;
        model_clear();
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
        tick();

        // 1: press floor 3 from floor 0, held throughout service.
        call_btn[3] = 1'b1;
        tick();
        tick();
        chk("t1_pend_early", 32'(pending), 32'h0);
        tick();
        chk("t1_pend_at3", 32'(pending), 32'h8);
        tick();
        chk("t1_rv_early", 32'(req_valid), 32'd0);
        tick();
        chk("t1_rv_at5", 32'(req_valid), 32'd1);
        chk("t1_rf", 32'(req_floor), 32'd3);

        // 4: arrival at 3 clears the lamp and holds the door for DOOR_CYCLES cycles.
        travel_to(3, "t4_door_on");
        chk("t4_pend_clr", 32'(pending), 32'h0);
        chk("t4_rv_low", 32'(req_valid), 32'd0);
        cnt = 1;
        for (int k = 0; k < 60 && door_open; k++) begin
            tick();
            if (door_open) cnt++;
        end
        chk("t4_door_len", 32'(cnt), 32'(DC));
        repeat (4) tick();
        chk("t1_held_once", 32'(pending), 32'h0);
        call_btn = '0;

        // 2: car at 5 heading up with calls at 2 and 7.
        current_floor = 4'd5;
        press(2, 7);
        wait_rv("t2_rv1");
        chk("t2_rf7", 32'(req_floor), 32'd7);
        chk("t2_dir_up", 32'(dir_up), 32'd1);
        travel_to(7, "t2_door7");
        wait_door_done("t2_door7_done");
        wait_rv("t2_rv2");
        chk("t2_rf2", 32'(req_floor), 32'd2);
        chk("t2_dir_dn", 32'(dir_up), 32'd0);
        travel_to(2, "t2_door2");
        wait_door_done("t2_door2_done");

        // 3: call at 4 while travelling to 8 does not retarget.
        press(8, 8);
        wait_rv("t3_rv8");
        chk("t3_rf8", 32'(req_floor), 32'd8);
        chk("t3_dir_rev", 32'(dir_up), 32'd1);
        arrived = 1'b0;
        press(4, 4);
        repeat (6) tick();
        chk("t3_pend4", 32'(pending[4]), 32'd1);
        chk("t3_rf_hold", 32'(req_floor), 32'd8);
        current_floor = 4'd8;
        arrived       = 1'b1;
        tick();
        chk("t3_door8", 32'(door_open), 32'd1);
        wait_door_done("t3_door8_done");
        wait_rv("t3_rv4");
        chk("t3_rf4", 32'(req_floor), 32'd4);
        travel_to(4, "t3_door4");
        wait_door_done("t3_door4_done");

        // 5: controller reports floor 12; nothing may be dispatched.
        current_floor = 4'd12;
        press(1, 6);
        chk("t5_err", 32'(floor_err), 32'd1);
        repeat (20) tick();
        chk("t5_rv_low", 32'(req_valid), 32'd0);
        chk("t5_pend", 32'(pending), 32'h42);

        // 6: valid floor again, dispatch, then reset while waiting for arrival.
        current_floor = 4'd3;
        arrived       = 1'b0;
        wait_rv("t6_rv");
        chk("t6_rf1", 32'(req_floor), 32'd1);
        chk("t6_err_sticky", 32'(floor_err), 32'd1);
        chk("t6_pend", 32'(pending), 32'h42);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        model_clear();
        @(negedge clk);
        check_all();
        reset         = 1'b0;
        current_floor = '0;
        arrived       = 1'b1;
        tick();
        check_reset_vals("t6_after");

        // Random traffic with the bench acting as the elevator controller.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < NF; i++) begin
                if (hold[i] > 0) hold[i]--;
                else if ($urandom_range(0, 59) == 0) hold[i] = $urandom_range(1, 6);
                call_btn[i] = (hold[i] > 0);
            end
            if (travel > 0) begin
                travel--;
                if (travel == 0) begin
                    current_floor = FW'(tgt);
                    arrived       = 1'b1;
                end
            end else if (req_valid && arrived && current_floor != req_floor) begin
                tgt     = int'(req_floor);
                travel  = $urandom_range(1, 8);
                arrived = 1'b0;
            end
            reset = (cyc == 2000);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
